sw8_loader: RTL
===============

Name: sw8_loader

Overview:
- Front-panel memory loader that drives the data RAM's switch-write port (sw8_write_en / sw8_addr / sw8_data).
- An operator enters an address, then data bytes, on 8 slide switches, committing each entry with a push button.
- The block debounces and synchronises the panel inputs, sequences the address/data entry FSM, and emits single-cycle write strobes.
- It holds the pipeline while loading is active.

Parameters:
- DB_CYCLES, 16'd50000: consecutive stable cycles required before a button level change is accepted; minimum 2.
- DB_W, 16: width of the debounce counter; must hold DB_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- sw  input  8  raw slide switches, asynchronous to clk.
- btn_load  input  1  raw commit push button, active-high, bouncy.
- load_mode  input  1  raw mode switch: 1 = loader active, 0 = CPU runs.
- sw8_write_en  output  1  one-cycle RAM write strobe.
- sw8_addr  output  8  RAM write address.
- sw8_data  output  8  RAM write data.
- cpu_hold  output  1  stalls the pipeline while loading.
- write_cnt  output  8  number of writes issued, wraps modulo 256.
- loader_state  output  2  current FSM state, for LEDs.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all synchroniser flops 0, debounce counter 0, stable button level 0, state IDLE.
- Input synchronisation:
  - sw, btn_load and load_mode each pass through a 2-flop synchroniser.
  - All logic uses only the synchronised values (sw_s, btn_s, mode_s).
- Debounce:
  - btn_stable is 0 after reset.
  - If btn_s != btn_stable, the counter increments each cycle. When the counter == DB_CYCLES-1 and the mismatch persists, btn_stable <= btn_s and the counter clears.
  - Any cycle with btn_s == btn_stable clears the counter.
  - press = btn_stable & ~btn_stable_d: a one-cycle pulse on the rising edge only. Releases generate nothing.
  - Latency from a clean raw rising edge to the press pulse is 2 + DB_CYCLES cycles.
- FSM states (loader_state encoding): IDLE=0, GET_ADDR=1, GET_DATA=2, WRITE=3.
  - IDLE: mode_s=1 -> GET_ADDR. Presses are ignored.
  - GET_ADDR: on press, addr_reg <= sw_s, then -> GET_DATA.
  - GET_DATA: on press, data_reg <= sw_s, then -> WRITE.
  - WRITE: lasts exactly one cycle, with sw8_write_en=1 and write_cnt incremented at the end of the cycle. Next state is GET_DATA, with addr_reg <= addr_reg+1. The increment wraps: 8'hFF -> 8'h00.
  - mode_s=0 in GET_ADDR or GET_DATA -> IDLE next cycle. A press in that same cycle is discarded.
  - mode_s=0 in WRITE: the write still completes (strobe already issued), then -> IDLE.
- Outputs:
  - sw8_write_en = (state==WRITE). It is never high for 2 consecutive cycles.
  - sw8_addr = addr_reg and sw8_data = data_reg, stable throughout the strobe. During WRITE, sw8_addr shows the pre-increment address.
  - cpu_hold = mode_s | (state != IDLE). It is asserted from the cycle mode_s rises until the cycle after the FSM returns to IDLE.
- addr_reg, data_reg and write_cnt retain their values across IDLE; only reset clears them.
- sw changes between presses have no effect. Only the value present on sw_s in the press cycle is captured.

Optional Feature:
- Macro: SW8_AUTOINC_EN.
- Defined: after WRITE, the address auto-increments (wrap at 255 -> 0) and the FSM returns to GET_DATA, so consecutive bytes need one press each.
- Undefined: after WRITE, addr_reg is unchanged and the FSM returns to GET_ADDR, so every byte needs an address press followed by a data press.
- All other behaviour is identical.

Test Plan (DB_CYCLES=4, SW8_AUTOINC_EN defined unless stated):
- Reset mid-WRITE:
  - Stimulus: drive rst=0 during the WRITE cycle.
  - Required: sw8_write_en drops immediately; all outputs 0; state IDLE; no write recorded.
- Single write:
  - Stimulus: load_mode=1; press with sw=8'h10; press with sw=8'hA5.
  - Required: exactly one strobe with sw8_addr=8'h10 and sw8_data=8'hA5; write_cnt=1; press pulse observed 6 cycles after the raw edge.
- Burst and wrap:
  - Stimulus: address 8'hFE, then data 8'h01, 8'h02, 8'h03.
  - Required: writes to FE, FF and 00 respectively; write_cnt=3.
- Bounce rejection:
  - Stimulus: btn_load toggles every 2 cycles for 20 cycles, then stays high.
  - Required: exactly one press; no strobe during the bounce.
- Mode drop:
  - Stimulus: load_mode -> 0 while in GET_DATA, with a press in the same synchronised cycle.
  - Required: no strobe; IDLE next cycle; cpu_hold=0 one cycle later.
- Macro undefined:
  - Stimulus: address 8'h20, data 8'h11, then press with sw=8'h30.
  - Required: 8'h30 is taken as the new address (state GET_DATA); the first write went to 8'h20.

Source files
------------

// File: rtl/sw8_loader_if.sv
// RAM switch-write port: one-cycle strobe with address and data.
interface sw8_loader_if;
    logic       sw8_write_en;
    logic [7:0] sw8_addr;
    logic [7:0] sw8_data;

    modport master (output sw8_write_en, output sw8_addr, output sw8_data);
    modport slave  (input  sw8_write_en, input  sw8_addr, input  sw8_data);
endinterface

// File: rtl/sw8_loader.sv
// Front-panel RAM loader: synchronised switches, debounced commit button, address/data entry FSM.
// Define SW8_AUTOINC_EN for address auto-increment and GET_DATA return after each write.
module sw8_loader #(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   sw,
    input  logic         btn_load,
    input  logic         load_mode,
    sw8_loader_if.master sw8,
    output logic         cpu_hold,
    output logic [7:0]   write_cnt,
    output logic [1:0]   loader_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        WRITE    = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 16'd1);

    logic [7:0]      r_sw_m, r_sw_s;
    logic            r_btn_m, r_btn_s;
    logic            r_mode_m, r_mode_s;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_stable, r_btn_stable_d;
    logic            w_press;
    state_t          r_state, w_next;
    logic            w_ld_addr, w_ld_data;
    logic [7:0]      r_addr, r_data, r_wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_m   <= '0;
            r_sw_s   <= '0;
            r_btn_m  <= 1'b0;
            r_btn_s  <= 1'b0;
            r_mode_m <= 1'b0;
            r_mode_s <= 1'b0;
        end else begin
            r_sw_m   <= sw;
            r_sw_s   <= r_sw_m;
            r_btn_m  <= btn_load;
            r_btn_s  <= r_btn_m;
            r_mode_m <= load_mode;
            r_mode_s <= r_mode_m;
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt       <= '0;
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_btn_stable_d <= r_btn_stable;
            if (r_btn_s != r_btn_stable) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_stable <= r_btn_s;
                    r_db_cnt     <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press = r_btn_stable & ~r_btn_stable_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ld_addr = 1'b0;
        w_ld_data = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_mode_s) w_next = GET_ADDR;
            end
            GET_ADDR: begin
                if (!r_mode_s) begin
                    w_next = IDLE;
                end else if (w_press) begin
                    w_ld_addr = 1'b1;
                    w_next    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (!r_mode_s) begin
                    w_next = IDLE;
                end else if (w_press) begin
                    w_ld_data = 1'b1;
                    w_next    = WRITE;
                end
            end
            WRITE: begin
                if (!r_mode_s) begin
                    w_next = IDLE;
                end else begin
`ifdef SW8_AUTOINC_EN
                    w_next = GET_DATA;
`else
                    w_next = GET_ADDR;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_ld_addr) r_addr <= r_sw_s;
            if (w_ld_data) r_data <= r_sw_s;
            if (r_state == WRITE) begin
                r_wcnt <= r_wcnt + 8'd1;
`ifdef SW8_AUTOINC_EN
                r_addr <= r_addr + 8'd1;
`endif
            end
        end
    end

    assign sw8.sw8_write_en = (r_state == WRITE);
    assign sw8.sw8_addr     = r_addr;
    assign sw8.sw8_data     = r_data;
    assign cpu_hold         = r_mode_s | (r_state != IDLE);
    assign write_cnt        = r_wcnt;
    assign loader_state     = r_state;

endmodule
